doitgen_sched: RTL and testbench

Sequential controller that schedules the doitgen tensor contraction A[r][q][p] = Σ_s A[r][q][s]·X[s][p] over a packed 2×2×2 tensor. It uses one shared 8-bit multiply-accumulate unit driven by an r/q/p/s loop-counter FSM, with a start/busy/done handshake. It sits between the host-side operand registers and the result register. It replaces the single-cycle unrolled evaluation with a one-MAC-per-cycle datapath.

---
 rtl/doitgen_pkg.sv | 42 ++++
 rtl/doitgen_if.sv | 29 ++
 rtl/doitgen_mac.sv | 33 +++
 rtl/doitgen_sched.sv | 144 ++++++++++++++
 tb/tb_doitgen_sched.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/doitgen_pkg.sv
// doitgen_pkg: shared types, sizes and index helpers for the doitgen scheduler.
//   - state_t   : controller FSM states (IDLE, MAC, WB, FIN)
//   - W, DIM_MAX: element width and maximum loop extent
//   - N_A, N_X  : element counts of the A tensor (8) and X matrix (4)
//   - idx_a/idx_x map (r,q,s) / (s,p) to the flat element index
//   - clamp_dim limits a requested extent to DIM_MAX
package doitgen_pkg;

    localparam int W       = 8;
    localparam int DIM_MAX = 2;
    localparam int N_A     = 8;
    localparam int N_X     = 4;
    localparam int CW      = $clog2(DIM_MAX);   // loop counter width
    localparam int DW      = 2;                 // extent input width
    localparam int AW      = $clog2(N_A);
    localparam int XW      = $clog2(N_X);

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        WB,
        FIN
    } state_t;

    function automatic logic [AW-1:0] idx_a(logic [CW-1:0] r, logic [CW-1:0] q, logic [CW-1:0] s);
        return AW'(4 * r + 2 * q + s);
    endfunction

    function automatic logic [XW-1:0] idx_x(logic [CW-1:0] s, logic [CW-1:0] p);
        return XW'(2 * s + p);
    endfunction

    function automatic logic [DW-1:0] clamp_dim(logic [DW-1:0] d);
        return (d > DW'(DIM_MAX)) ? DW'(DIM_MAX) : d;
    endfunction

    // True when counter c is on the last iteration of a loop of extent n.
    function automatic logic is_last(logic [CW-1:0] c, logic [DW-1:0] n);
        return (DW'(c) + DW'(1)) == n;
    endfunction

endpackage

// File: rtl/doitgen_if.sv
// doitgen_if: host <-> scheduler handshake and operand/result bus.
//   start       host request (sampled by the scheduler only when idle)
//   a_in, x_in  packed A tensor / X matrix, element 0 in the MSBs
//   nr, nq, np  loop extents
//   busy, done  job in progress / one-cycle result-valid pulse
//   aout        packed result tensor, held until the next done
interface doitgen_if #(
    parameter int W = doitgen_pkg::W
);
    logic           start;
    logic [8*W-1:0] a_in;
    logic [4*W-1:0] x_in;
    logic [1:0]     nr;
    logic [1:0]     nq;
    logic [1:0]     np;
    logic           busy;
    logic           done;
    logic [8*W-1:0] aout;

    modport master (
        output start, a_in, x_in, nr, nq, np,
        input  busy, done, aout
    );

    modport slave (
        input  start, a_in, x_in, nr, nq, np,
        output busy, done, aout
    );
endinterface

// File: rtl/doitgen_mac.sv
// doitgen_mac: combinational multiply-accumulate o_sum = i_acc + i_a * i_x.
//   i_acc, i_a, i_x : W-bit accumulator and operands
//   o_sum           : W-bit result
// Build option DOITGEN_SAT_EN: product and sum saturate at 2^W-1;
// otherwise the product truncates and the sum wraps modulo 2^W.
module doitgen_mac #(
    parameter int W = 8
) (
    input  logic [W-1:0] i_acc,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_x,
    output logic [W-1:0] o_sum
);
    import doitgen_pkg::*;

`ifdef DOITGEN_SAT_EN
    logic [2*W-1:0] w_prod;
    logic [W-1:0]   w_prod_sat;
    logic [W:0]     w_sum_full;

    assign w_prod     = {{W{1'b0}}, i_a} * {{W{1'b0}}, i_x};
    assign w_prod_sat = (|w_prod[2*W-1:W]) ? {W{1'b1}} : w_prod[W-1:0];
    assign w_sum_full = {1'b0, i_acc} + {1'b0, w_prod_sat};
    assign o_sum      = w_sum_full[W] ? {W{1'b1}} : w_sum_full[W-1:0];
`else
    logic [W-1:0] w_prod;

    // W-bit context keeps only the low half of the product.
    assign w_prod = i_a * i_x;
    assign o_sum  = i_acc + w_prod;
`endif

endmodule

// File: rtl/doitgen_sched.sv
// doitgen_sched: one-MAC-per-cycle scheduler for A[r][q][p] = sum_s A[r][q][s]*X[s][p]
// over a packed 2x2x2 tensor.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; aborts any job in flight
//   bus    doitgen_if slave: start/a_in/x_in/nr/nq/np in, busy/done/aout out
// Build option DOITGEN_SAT_EN (in doitgen_mac) selects saturating arithmetic.
module doitgen_sched #(
    parameter int W = doitgen_pkg::W
) (
    input  logic     clk,
    input  logic     rst_n,
    doitgen_if.slave bus
);
    import doitgen_pkg::*;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [W-1:0]     r_a   [N_A];
    logic [W-1:0]     r_x   [N_X];
    logic [W-1:0]     r_acc [DIM_MAX];
    logic [W-1:0]     w_a_wb [N_A];
    logic [N_A*W-1:0] w_a_wb_flat;
    logic [N_A*W-1:0] r_aout;
    logic [CW-1:0]    r_r, r_q, r_p, r_s;
    logic [DW-1:0]    r_nr, r_nq, r_np;
    logic [DW-1:0]    w_nr, w_nq, w_np;
    logic             w_zero_dim;
    logic             w_s_last, w_p_last, w_q_last, w_r_last;
    logic [W-1:0]     w_mac_sum;

    assign w_nr       = clamp_dim(bus.nr);
    assign w_nq       = clamp_dim(bus.nq);
    assign w_np       = clamp_dim(bus.np);
    assign w_zero_dim = (w_nr == '0) || (w_nq == '0) || (w_np == '0);

    // The reduction index s runs over the same extent as p.
    assign w_s_last = is_last(r_s, r_np);
    assign w_p_last = is_last(r_p, r_np);
    assign w_q_last = is_last(r_q, r_nq);
    assign w_r_last = is_last(r_r, r_nr);

    doitgen_mac #(.W(W)) u_mac (
        .i_acc (r_acc[r_p]),
        .i_a   (r_a[idx_a(r_r, r_q, r_s)]),
        .i_x   (r_x[idx_x(r_s, r_p)]),
        .o_sum (w_mac_sum)
    );

    // Working A with the current row's accumulators written back. Used both
    // for the WB update and to load aout on the edge into FIN, so that done
    // and the new aout appear in the same cycle.
    always_comb begin
        // NOTE: every combinational output gets a default before any
        // conditional assignment, otherwise a latch is inferred.
        w_a_wb_flat = '0;
        for (int i = 0; i < N_A; i++) w_a_wb[i] = r_a[i];
        for (int pp = 0; pp < DIM_MAX; pp++) begin
            if (DW'(pp) < r_np) w_a_wb[idx_a(r_r, r_q, CW'(pp))] = r_acc[pp];
        end
        for (int i = 0; i < N_A; i++) w_a_wb_flat[N_A*W-1-W*i -: W] = w_a_wb[i];
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_state_nxt = w_zero_dim ? FIN : MAC;
            MAC:     if (w_s_last && w_p_last) w_state_nxt = WB;
            WB:      w_state_nxt = (w_q_last && w_r_last) ? FIN : MAC;
            FIN:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, independent of statement order.
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the small operand/accumulator arrays are reset explicitly
            // so an aborted job leaves no stale data visible anywhere.
            for (int i = 0; i < N_A; i++) r_a[i] <= '0;
            for (int i = 0; i < N_X; i++) r_x[i] <= '0;
            for (int i = 0; i < DIM_MAX; i++) r_acc[i] <= '0;
            r_aout <= '0;
            r_r    <= '0;
            r_q    <= '0;
            r_p    <= '0;
            r_s    <= '0;
            r_nr   <= '0;
            r_nq   <= '0;
            r_np   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        for (int i = 0; i < N_A; i++) r_a[i] <= bus.a_in[N_A*W-1-W*i -: W];
                        for (int j = 0; j < N_X; j++) r_x[j] <= bus.x_in[N_X*W-1-W*j -: W];
                        for (int i = 0; i < DIM_MAX; i++) r_acc[i] <= '0;
                        r_nr <= w_nr;
                        r_nq <= w_nq;
                        r_np <= w_np;
                        r_r  <= '0;
                        r_q  <= '0;
                        r_p  <= '0;
                        r_s  <= '0;
                        if (w_zero_dim) r_aout <= bus.a_in;
                    end
                end
                MAC: begin
                    r_acc[r_p] <= w_mac_sum;
                    if (w_s_last) begin
                        r_s <= '0;
                        r_p <= w_p_last ? '0 : r_p + 1'b1;
                    end else begin
                        r_s <= r_s + 1'b1;
                    end
                end
                WB: begin
                    for (int i = 0; i < N_A; i++) r_a[i] <= w_a_wb[i];
                    for (int i = 0; i < DIM_MAX; i++) r_acc[i] <= '0;
                    r_p <= '0;
                    r_s <= '0;
                    if (w_q_last) begin
                        r_q <= '0;
                        r_r <= w_r_last ? '0 : r_r + 1'b1;
                    end else begin
                        r_q <= r_q + 1'b1;
                    end
                    if (w_q_last && w_r_last) r_aout <= w_a_wb_flat;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (r_state != IDLE);
    assign bus.done = (r_state == FIN);
    assign bus.aout = r_aout;

endmodule

// File: tb/tb_doitgen_sched.sv
// tb_doitgen_sched: scoreboard bench for doitgen_sched. Each launched job pushes
// its expected aout and latency (from a loop-nest reference model) onto a
// queue; each done pops and compares.
module tb_doitgen_sched;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    doitgen_if #(.W(8)) bus ();

    doitgen_sched #(.W(8)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    typedef struct {
        logic [63:0] aout;
        int          n;
        int          k;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic int clampi(input logic [1:0] d);
        return (d > 2'd2) ? 2 : int'(d);
    endfunction

    function automatic int latency(input logic [1:0] nr, input logic [1:0] nq, input logic [1:0] np);
        int cr = clampi(nr);
        int cq = clampi(nq);
        int cp = clampi(np);
        if (cr == 0 || cq == 0 || cp == 0) return 1;
        return cr * cq * (cp * cp + 1) + 1;
    endfunction

    function automatic logic [63:0] model(input logic [63:0] a, input logic [31:0] x,
                                          input logic [1:0] nr, input logic [1:0] nq,
                                          input logic [1:0] np);
        logic [63:0] res = a;
        logic [7:0]  acc, ea, ex;
        logic [15:0] prod;
        logic [8:0]  sum;
        int cr = clampi(nr);
        int cq = clampi(nq);
        int cp = clampi(np);
        if (cr == 0 || cq == 0 || cp == 0) return a;
        for (int r = 0; r < cr; r++)
            for (int q = 0; q < cq; q++)
                for (int p = 0; p < cp; p++) begin
                    acc = 8'h00;
                    for (int s = 0; s < cp; s++) begin
                        ea   = a[63-8*(4*r+2*q+s) -: 8];
                        ex   = x[31-8*(2*s+p) -: 8];
                        prod = {8'h00, ea} * {8'h00, ex};
`ifdef DOITGEN_SAT_EN
                        if (prod > 16'd255) prod = 16'd255;
                        sum = {1'b0, acc} + {1'b0, prod[7:0]};
                        acc = sum[8] ? 8'hFF : sum[7:0];
`else
                        sum = {1'b0, acc} + {1'b0, prod[7:0]};
                        acc = sum[7:0];
`endif
                    end
                    res[63-8*(4*r+2*q+p) -: 8] = acc;
                end
        return res;
    endfunction

    // Call at a negedge with the DUT idle; returns one cycle after acceptance.
    task automatic launch(input logic [63:0] a, input logic [31:0] x,
                          input logic [1:0] nr, input logic [1:0] nq, input logic [1:0] np);
        exp_t e;
        bus.a_in  = a;
        bus.x_in  = x;
        bus.nr    = nr;
        bus.nq    = nq;
        bus.np    = np;
        bus.start = 1'b1;
        e.aout = model(a, x, nr, nq, np);
        e.n    = latency(nr, nq, np);
        e.k    = edge_cnt + 1;
        sb.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
        check("busy_after_start", bus.busy, 1'b1);
    endtask

    // Returns at the negedge in which done is observed.
    task automatic wait_done();
        exp_t e;
        bit   seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("done_seen", seen, 1'b1);
        check("sb_nonempty", sb.size() != 0, 1'b1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        if (seen) begin
            check("aout", bus.aout, e.aout);
            check("latency", 64'(edge_cnt - e.k + 1), 64'(e.n));
        end
    endtask

    task automatic run_job(input logic [63:0] a, input logic [31:0] x,
                           input logic [1:0] nr, input logic [1:0] nq, input logic [1:0] np);
        launch(a, x, nr, nq, np);
        wait_done();
        @(negedge clk);
        check("busy_drop", bus.busy, 1'b0);
        check("done_pulse", bus.done, 1'b0);
    endtask

    task automatic no_extra_done(input int cycles);
        int extra = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (bus.done) extra++;
        end
        check("no_extra_done", extra, 0);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.a_in  = '0;
        bus.x_in  = '0;
        bus.nr    = 2'd0;
        bus.nq    = 2'd0;
        bus.np    = 2'd0;

        repeat (2) @(negedge clk);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_aout", bus.aout, 64'h0);
        rst_n = 1'b1;
        @(negedge clk);

        run_job(64'h0102030405060708, 32'h01000001, 2'd2, 2'd2, 2'd2);   // identity
        run_job(64'h0102030405060708, 32'h02000002, 2'd2, 2'd2, 2'd2);   // scaling
        run_job(64'hFFFFFFFFFFFFFFFF, 32'h02000002, 2'd2, 2'd2, 2'd2);   // overflow
        run_job(64'h0102030405060708, 32'h03000000, 2'd2, 2'd2, 2'd1);   // np=1
        run_job(64'h1122334455667788, 32'h05060708, 2'd2, 2'd0, 2'd2);   // nq=0
        run_job(64'h8877665544332211, 32'h01020304, 2'd3, 2'd3, 2'd3);   // clamp
        run_job(64'hA5A5A5A5A5A5A5A5, 32'hFF7F0180, 2'd1, 2'd2, 2'd2);
        for (int t = 0; t < 6; t++)
            run_job({$urandom, $urandom}, $urandom, 2'($urandom_range(0, 3)),
                    2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));

        // start and operand changes while busy must be ignored.
        launch(64'h0102030405060708, 32'h02000002, 2'd2, 2'd2, 2'd2);
        repeat (4) @(negedge clk);
        bus.a_in  = 64'hDEADBEEFCAFEF00D;
        bus.x_in  = 32'h11111111;
        bus.nq    = 2'd0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done();
        // Start raised in the done cycle; taken on the edge after the IDLE cycle.
        bus.start = 1'b1;
        @(negedge clk);
        check("idle_gap_busy", bus.busy, 1'b0);
        check("idle_gap_done", bus.done, 1'b0);
        launch(64'h0F0E0D0C0B0A0908, 32'h01010101, 2'd2, 2'd1, 2'd2);
        wait_done();
        @(negedge clk);
        check("busy_drop_b2b", bus.busy, 1'b0);
        no_extra_done(30);

        // Reset mid-job: everything clears, aborted job never signals done.
        launch(64'h0102030405060708, 32'h01000001, 2'd2, 2'd2, 2'd2);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", bus.busy, 1'b0);
        check("abort_done", bus.done, 1'b0);
        check("abort_aout", bus.aout, 64'h0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        no_extra_done(25);
        run_job(64'h0102030405060708, 32'h03000000, 2'd2, 2'd2, 2'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

endmodule
